// File: rtl/mdu_if.sv
// Operand, control and result bundle between the execute stage and the MDU.
interface mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       MDUOp;
    logic             start;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rdata;

    // Execute stage / pipeline side
    modport master (
        output a, b, MDUOp, start, cancel,
        input  busy, hi, lo, rdata
    );

    // MDU side
    modport slave (
        input  a, b, MDUOp, start, cancel,
        output busy, hi, lo, rdata
    );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Results are computed at
// issue into a shadow pair and committed to HI/LO after a fixed latency, so HI/LO
// keep their old values while busy and a cancel simply drops the shadow.
module mdu #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'b0001;
    localparam logic [3:0] OpMultu = 4'b0010;
    localparam logic [3:0] OpDiv   = 4'b0011;
    localparam logic [3:0] OpDivu  = 4'b0100;
    localparam logic [3:0] OpMthi  = 4'b0101;
    localparam logic [3:0] OpMtlo  = 4'b0110;
    localparam logic [3:0] OpMfhi  = 4'b0111;
    localparam logic [3:0] OpMflo  = 4'b1000;

    logic [WIDTH-1:0]   hi, lo, hi_n, lo_n;
    logic [CntW-1:0]    cnt;
    logic               wr_en;
    logic [2*WIDTH-1:0] prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

    // Full-width product; sign-extending to 2*WIDTH makes the low half the signed product.
    always_comb begin
        prod = '0;
        if (bus.MDUOp == OpMult) begin
            prod = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
        end else begin
            prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
        end
    end

    // Signed divide via magnitudes; MIN_INT / -1 wraps naturally to MIN_INT rem 0.
    always_comb begin
        a_neg   = (bus.MDUOp == OpDiv) && bus.a[WIDTH-1];
        b_neg   = (bus.MDUOp == OpDiv) && bus.b[WIDTH-1];
        a_mag   = a_neg ? -bus.a : bus.a;
        b_mag   = b_neg ? -bus.b : bus.b;
        // Dummy divisor on b=0; the result is discarded because wr_en stays low.
        divisor = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem     = a_neg ? -r_mag : r_mag;
    end

    // Issue, countdown, commit and cancel of HI/LO operations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            hi_n  <= '0;
            lo_n  <= '0;
            cnt   <= '0;
            wr_en <= 1'b0;
        end else if (cnt != '0) begin
            if (bus.cancel) begin
                cnt   <= '0;
                wr_en <= 1'b0;
            end else begin
                cnt <= cnt - CntW'(1);
                if (cnt == CntW'(1)) begin
                    wr_en <= 1'b0;
                    if (wr_en) begin
                        hi <= hi_n;
                        lo <= lo_n;
                    end
                end
            end
        end else if (bus.start && !bus.cancel) begin
            case (bus.MDUOp)
                OpMult, OpMultu: begin
                    {hi_n, lo_n} <= prod;
                    cnt          <= CntW'(MULT_CYCLES);
                    wr_en        <= 1'b1;
                end
                OpDiv, OpDivu: begin
                    hi_n  <= rem;
                    lo_n  <= quot;
                    cnt   <= CntW'(DIV_CYCLES);
                    wr_en <= (bus.b != '0);
                end
                OpMthi:  hi <= bus.a;
                OpMtlo:  lo <= bus.a;
                default: ;
            endcase
        end
    end

    // Zero-latency move-from read port.
    always_comb begin
        bus.rdata = '0;
        case (bus.MDUOp)
            OpMfhi:  bus.rdata = hi;
            OpMflo:  bus.rdata = lo;
            default: bus.rdata = '0;
        endcase
    end

    assign bus.busy = (cnt != '0);
    assign bus.hi   = hi;
    assign bus.lo   = lo;
endmodule
